alu_arbiter: RTL and testbench

- Shares one registered alu instance between N_REQ independent requesters.
- Round-robin arbitration issues at most one operation per cycle into the alu.
- Tags each issue with a wrapping sequence number carried on the alu addr_in/addr_out path.
- Captures each alu result one cycle after issue and returns it, with its tag, through a one-entry per-requester response buffer with valid/ready handshake.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/alu_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_arbiter.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared alu types, plus the constants the arbiter uses to drive the alu when no request wins.
package alu_pkg;

    localparam int OP_W  = 8;
    localparam int RES_W = OP_W;
    localparam int OPC_W = 3;

    typedef logic [OP_W-1:0]  OP_T;
    typedef logic [RES_W-1:0] RESULT_T;

    // Code 3'd7 is deliberately unassigned; the alu treats it as illegal and holds its result.
    typedef enum logic [OPC_W-1:0] {
        ADD    = 3'd0,
        SUB    = 3'd1,
        AND_OP = 3'd2,
        OR_OP  = 3'd3,
        NEGA   = 3'd4,
        PASSA  = 3'd5,
        PASSB  = 3'd6
    } OPCODE_T;

    localparam OPCODE_T ALU_IDLE_OPC = PASSA;
    localparam int      ALU_LATENCY  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: grants the first eligible index at or above ptr, wrapping modulo N.
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    eligible,
    input  logic [ID_W-1:0] ptr,
    output logic [N-1:0]    grant
);

    always_comb begin
        // NOTE: grant gets a full default before the search so no path leaves it unassigned (no latch).
        grant = '0;
        for (int k = 0; k < N; k++) begin
            int              pos;
            logic [ID_W-1:0] idx;
            pos = int'(ptr) + k;
            if (pos >= N) pos = pos - N;
            idx = ID_W'(pos);
            if (grant == '0 && eligible[idx]) grant[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered alu among N_REQ requesters: round-robin issue, tag on the addr path,
// and a one-entry valid/ready response slot per requester.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       req_valid,
    output logic [N_REQ-1:0]       req_ready,
    input  logic [N_REQ*OP_W-1:0]  req_a,
    input  logic [N_REQ*OP_W-1:0]  req_b,
    input  logic [N_REQ*OPC_W-1:0] req_opcode,
    output logic [N_REQ-1:0]       rsp_valid,
    input  logic [N_REQ-1:0]       rsp_ready,
    output logic [N_REQ*RES_W-1:0] rsp_result,
    output logic [N_REQ*OP_W-1:0]  rsp_tag,
    output logic [OP_W-1:0]        alu_a,
    output logic [OP_W-1:0]        alu_b,
    output logic [OPC_W-1:0]       alu_opcode,
    output logic [OP_W-1:0]        alu_addr_in,
    input  logic [RES_W-1:0]       alu_result,
    input  logic [OP_W-1:0]        alu_addr_out,
    output logic                   addr_err
);

    OP_T              a_arr   [N_REQ];
    OP_T              b_arr   [N_REQ];
    logic [OPC_W-1:0] opc_arr [N_REQ];
    RESULT_T          res_q   [N_REQ];
    OP_T              tag_q   [N_REQ];

    logic [N_REQ-1:0] eligible;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  ptr;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  ptr_next;
    logic [ID_W-1:0]  inflight_id;
    logic             run;
    logic             any_grant;
    logic             inflight_valid;
    OP_T              seq;
    OP_T              inflight_tag;

    for (genvar i = 0; i < N_REQ; i++) begin : g_req
        assign a_arr[i]   = req_a[i*OP_W +: OP_W];
        assign b_arr[i]   = req_b[i*OP_W +: OP_W];
        assign opc_arr[i] = req_opcode[i*OPC_W +: OPC_W];
        assign rsp_result[i*RES_W +: RES_W] = res_q[i];
        assign rsp_tag[i*OP_W +: OP_W]      = tag_q[i];
        // A requester waits out its own in-flight op, and its slot must be empty or draining.
        assign eligible[i] = run && req_valid[i]
                           && !(inflight_valid && inflight_id == ID_W'(i))
                           && (!rsp_valid[i] || rsp_ready[i]);
    end

    rr_arbiter #(.N(N_REQ), .ID_W(ID_W)) u_rr (
        .eligible (eligible),
        .ptr      (ptr),
        .grant    (grant)
    );

    assign req_ready   = grant;
    assign any_grant   = |grant;
    assign alu_addr_in = seq;
    assign ptr_next    = (winner == ID_W'(N_REQ - 1)) ? '0 : winner + 1'b1;

    always_comb begin
        winner = '0;
        for (int i = 0; i < N_REQ; i++)
            if (grant[i]) winner = ID_W'(i);
    end

    always_comb begin
        alu_a      = '0;
        alu_b      = '0;
        alu_opcode = ALU_IDLE_OPC;
        if (any_grant) begin
            alu_a      = a_arr[winner];
            alu_b      = b_arr[winner];
            alu_opcode = opc_arr[winner];
        end
    end

    // run holds off issue until the first edge after reset release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run            <= 1'b0;
            ptr            <= '0;
            seq            <= '0;
            inflight_valid <= 1'b0;
            inflight_id    <= '0;
            inflight_tag   <= '0;
            addr_err       <= 1'b0;
        end else begin
            // NOTE: state updates use <= so every flop samples pre-edge values regardless of order.
            run            <= 1'b1;
            inflight_valid <= any_grant;
            if (any_grant) begin
                ptr          <= ptr_next;
                seq          <= seq + 1'b1;
                inflight_id  <= winner;
                inflight_tag <= seq;
                if (alu_addr_out != alu_addr_in) addr_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= '0;
            // NOTE: slot storage is reset too, because its contents are visible on rsp_result/rsp_tag.
            for (int i = 0; i < N_REQ; i++) begin
                res_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++)
                if (rsp_valid[i] && rsp_ready[i]) rsp_valid[i] <= 1'b0;
            // A capture landing on the drain edge overrides the clear and reloads the slot.
            if (inflight_valid) begin
                rsp_valid[inflight_id] <= 1'b1;
                res_q[inflight_id]     <= alu_result;
                tag_q[inflight_id]     <= inflight_tag;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level model of the
// arbitration, tagging and response-slot rules, with a behavioural registered alu attached.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = $clog2(N);

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N*OP_W-1:0]    req_a;
    logic [N*OP_W-1:0]    req_b;
    logic [N*OPC_W-1:0]   req_opcode;
    logic [N-1:0]         rsp_valid;
    logic [N-1:0]         rsp_ready;
    logic [N*RES_W-1:0]   rsp_result;
    logic [N*OP_W-1:0]    rsp_tag;
    logic [OP_W-1:0]      alu_a;
    logic [OP_W-1:0]      alu_b;
    logic [OPC_W-1:0]     alu_opcode;
    logic [OP_W-1:0]      alu_addr_in;
    logic [RES_W-1:0]     alu_result;
    logic [OP_W-1:0]      alu_addr_out;
    logic                 addr_err;
    logic [OP_W-1:0]      corrupt;

    int n_checks = 0;
    int n_err    = 0;

    alu_arbiter #(.N_REQ(N), .ID_W(ID_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_opcode   (req_opcode),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_tag      (rsp_tag),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_opcode   (alu_opcode),
        .alu_addr_in  (alu_addr_in),
        .alu_result   (alu_result),
        .alu_addr_out (alu_addr_out),
        .addr_err     (addr_err)
    );

    always #5 clk = ~clk;

    function automatic bit legal_op(input logic [OPC_W-1:0] op);
        return op <= 3'd6;
    endfunction

    function automatic logic [RES_W-1:0] alu_ref(input logic [OPC_W-1:0] op,
                                                 input logic [OP_W-1:0] a,
                                                 input logic [OP_W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return -a;
            3'd5:    return a;
            3'd6:    return b;
            default: return 'x;
        endcase
    endfunction

    // External alu: one-cycle registered result, illegal opcode holds the old result.
    always @(posedge clk)
        if (legal_op(alu_opcode)) alu_result <= alu_ref(alu_opcode, alu_a, alu_b);

    assign alu_addr_out = alu_addr_in ^ corrupt;

    // Reference model state.
    typedef struct {
        int               id;
        logic [OP_W-1:0]  tag;
        logic [RES_W-1:0] res;
        bit               legal;
        int unsigned      land;
    } pend_t;

    pend_t            pend[$];
    bit               sv_valid [N];
    logic [OP_W-1:0]  sv_tag   [N];
    logic [RES_W-1:0] sv_res   [N];
    bit               sv_legal [N];
    bit               active;
    bit               err_m;
    int               ptr_m;
    logic [OP_W-1:0]  seq_m;
    int unsigned      cyc;
    int               n_issue;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < N; i++) begin
            sv_valid[i] = 1'b0;
            sv_legal[i] = 1'b0;
            sv_tag[i]   = '0;
            sv_res[i]   = '0;
        end
        active = 1'b0;
        err_m  = 1'b0;
        ptr_m  = 0;
        seq_m  = '0;
    endtask

    function automatic bit in_flight(input int id);
        foreach (pend[j]) if (pend[j].id == id) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_req(input int i, input logic [OPC_W-1:0] op,
                           input logic [OP_W-1:0] a, input logic [OP_W-1:0] b);
        req_opcode[i*OPC_W +: OPC_W] = op;
        req_a[i*OP_W +: OP_W]        = a;
        req_b[i*OP_W +: OP_W]        = b;
    endtask

    // One clock cycle: inputs already driven after the falling edge; check, advance model, clock.
    task automatic step();
        int           win;
        logic [N-1:0] exp_ready;
        #1;
        if (!reset_n) begin
            check("rst_req_ready",  32'(req_ready),  '0);
            check("rst_rsp_valid",  32'(rsp_valid),  '0);
            check("rst_rsp_result", 32'(rsp_result), '0);
            check("rst_rsp_tag",    32'(rsp_tag),    '0);
            check("rst_addr_err",   32'(addr_err),   '0);
            model_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("rsp_valid%0d", i), 32'(rsp_valid[i]), 32'(sv_valid[i]));
                if (sv_valid[i]) begin
                    check($sformatf("rsp_tag%0d", i), 32'(rsp_tag[i*OP_W +: OP_W]), 32'(sv_tag[i]));
                    if (sv_legal[i])
                        check($sformatf("rsp_result%0d", i),
                              32'(rsp_result[i*RES_W +: RES_W]), 32'(sv_res[i]));
                end
            end
            win = -1;
            if (active) begin
                for (int k = 0; k < N; k++) begin
                    int idx;
                    idx = (ptr_m + k) % N;
                    if (win < 0 && req_valid[idx] && !in_flight(idx) && (!sv_valid[idx] || rsp_ready[idx]))
                        win = idx;
                end
            end
            exp_ready = (win >= 0) ? (N'(1) << win) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("alu_addr_in", 32'(alu_addr_in), 32'(seq_m));
            if (win >= 0) begin
                check("alu_a",      32'(alu_a),      32'(req_a[win*OP_W +: OP_W]));
                check("alu_b",      32'(alu_b),      32'(req_b[win*OP_W +: OP_W]));
                check("alu_opcode", 32'(alu_opcode), 32'(req_opcode[win*OPC_W +: OPC_W]));
            end else begin
                check("idle_a",      32'(alu_a),      '0);
                check("idle_b",      32'(alu_b),      '0);
                check("idle_opcode", 32'(alu_opcode), 32'(PASSA));
            end
            check("addr_err", 32'(addr_err), 32'(err_m));

            // Effects of the coming edge: drain, then capture (capture wins), then issue.
            for (int i = 0; i < N; i++)
                if (sv_valid[i] && rsp_ready[i]) sv_valid[i] = 1'b0;
            for (int j = pend.size() - 1; j >= 0; j--) begin
                if (pend[j].land == cyc) begin
                    sv_valid[pend[j].id] = 1'b1;
                    sv_tag[pend[j].id]   = pend[j].tag;
                    sv_res[pend[j].id]   = pend[j].res;
                    sv_legal[pend[j].id] = pend[j].legal;
                    pend.delete(j);
                end
            end
            if (win >= 0) begin
                pend_t p;
                p.id    = win;
                p.tag   = seq_m;
                p.legal = legal_op(req_opcode[win*OPC_W +: OPC_W]);
                p.res   = alu_ref(req_opcode[win*OPC_W +: OPC_W], req_a[win*OP_W +: OP_W],
                                  req_b[win*OP_W +: OP_W]);
                p.land  = cyc + 1;
                pend.push_back(p);
                if (corrupt != '0) err_m = 1'b1;
                ptr_m = (win + 1) % N;
                seq_m = seq_m + 1'b1;
                n_issue++;
            end
            active = 1'b1;
            cyc++;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n    = 1'b0;
        req_valid  = '1;
        rsp_ready  = '0;
        req_a      = '0;
        req_b      = '0;
        req_opcode = '0;
        corrupt    = '0;
        cyc        = 0;
        n_issue    = 0;
        model_reset();
        @(negedge clk);

        // Reset with requests pending: nothing granted, all outputs cleared.
        repeat (2) step();
        reset_n   = 1'b1;
        req_valid = '0;
        step();

        // Single request: ADD 5+3 from requester 0, response two cycles later with tag 0.
        set_req(0, ADD, 8'd5, 8'd3);
        req_valid = 4'b0001;
        #1 check("single_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        repeat (2) step();
        #1;
        check("single_rsp_valid",  32'(rsp_valid[0]),      32'h1);
        check("single_rsp_result", 32'(rsp_result[7:0]),   32'h8);
        check("single_rsp_tag",    32'(rsp_tag[7:0]),      32'h0);
        step();
        rsp_ready = '1;
        step();

        // All requesters streaming with responses always accepted.
        set_req(0, ADD,   8'd5, 8'd3);
        set_req(1, SUB,   8'd9, 8'd4);
        set_req(2, NEGA,  8'd1, 8'd0);
        set_req(3, PASSB, 8'd0, 8'd7);
        req_valid = '1;
        repeat (12) step();

        // Backpressure on requester 2: its slot fills and no new grant goes to it.
        rsp_ready = 4'b1011;
        repeat (8) step();
        #1;
        check("bp_slot_full", 32'(rsp_valid[2]), 32'h1);
        check("bp_no_grant",  32'(req_ready[2]), 32'h0);
        req_valid = 4'b0100;
        rsp_ready = '1;
        #1 check("bp_release_grant", 32'(req_ready), 32'h4);
        step();
        req_valid = '1;
        repeat (6) step();

        // Illegal opcode is still issued and tagged; its result is not checked.
        set_req(1, 3'd7, 8'd1, 8'd2);
        req_valid = 4'b0010;
        repeat (6) step();

        // Randomized traffic long enough to wrap the sequence counter.
        for (int n = 0; n < 800; n++) begin
            req_valid = N'($urandom);
            for (int i = 0; i < N; i++) begin
                rsp_ready[i] = ($urandom_range(3) != 0);
                set_req(i, OPC_W'($urandom_range(7)), OP_W'($urandom), OP_W'($urandom));
            end
            step();
        end
        #1 check("wrap_addr_err", 32'(addr_err), 32'h0);

        // Reset the cycle after requester 1 issues: its response must never appear.
        req_valid = 4'b0010;
        rsp_ready = '1;
        set_req(1, ADD, 8'd2, 8'd2);
        step();
        reset_n   = 1'b0;
        req_valid = '1;
        repeat (2) step();
        reset_n = 1'b1;
        step();
        for (int i = 0; i < N; i++) set_req(i, ADD, OP_W'(i + 1), 8'd10);
        #1;
        check("post_rst_grant", 32'(req_ready),   32'h1);
        check("post_rst_tag",   32'(alu_addr_in), 32'h0);
        repeat (6) step();

        // Tag corruption: ignored while idle, sticky once seen on an issue, cleared by reset.
        req_valid = '0;
        corrupt   = 8'h10;
        step();
        req_valid = 4'b0001;
        step();
        corrupt   = '0;
        req_valid = '0;
        repeat (3) step();
        #1 check("addr_err_sticky", 32'(addr_err), 32'h1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
